// File: rtl/data_sync_pkg.sv
// Shared types and helpers for the source-domain bus-synchronizer launcher.
package data_sync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK_LOW = 2'd2
    } state_t;

    // Width of a counter that must hold values 0..limit, never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset to 0.
module bit_sync #(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [NUM_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[NUM_STAGES-2:0], d};
        end
    end

    assign q = chain[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_launch.sv
// Launches one word at a time toward a destination bus synchronizer using a
// 4-phase req/ack handshake; the bus is held stable until ack returns low.
module data_sync_launch
    import data_sync_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 2,
    parameter int unsigned BUS_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic                 ack_async,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    output logic                 done_pulse,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned       CNT_W      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);
    localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t            state;
    logic              ack_sync;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              accept;
    logic              entering;
    logic              waiting;

    bit_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_ack_sync (
        .clk(clk),
        .rst(rst),
        .d  (ack_async),
        .q  (ack_sync)
    );

    // A stale high ack keeps the launcher closed even when idle.
    assign data_ready = (state == IDLE) && !ack_sync;
    assign accept     = data_valid && data_ready;
    assign entering   = accept || ((state == REQ) && ack_sync);
    assign waiting    = ((state == REQ) && !ack_sync) || ((state == ACK_LOW) && ack_sync);
    assign cnt_next   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            unsync_bus <= '0;
            bus_enable <= 1'b0;
            done_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unsync_bus <= data_in;
                        bus_enable <= 1'b1;
                        busy       <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (ack_sync) begin
                        bus_enable <= 1'b0;
                        state      <= ACK_LOW;
                    end
                end
                ACK_LOW: begin
                    if (!ack_sync) begin
                        done_pulse <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    bus_enable <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Per-phase wait counter; the transfer keeps waiting after a timeout is flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else if (TIMEOUT_EN) begin
            if (entering) begin
                cnt <= '0;
            end else if (waiting) begin
                cnt <= cnt_next;
                if (cnt_next == CNT_MAX) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sync_launch.sv
// Randomised and directed bench for data_sync_launch with a transaction-level model,
// scoreboard queues and a behavioural destination synchronizer.
module tb_data_sync_launch;

    localparam int unsigned NS = 2;
    localparam int unsigned BW = 8;
    localparam int unsigned TO = 10;

    logic          clk     = 1'b0;
    logic          dst_clk = 1'b0;
    logic          rst     = 1'b1;
    logic [BW-1:0] data_in;
    logic          data_valid;
    logic          data_ready;
    logic          ack_async;
    logic [BW-1:0] unsync_bus;
    logic          bus_enable;
    logic          done_pulse;
    logic          busy;
    logic          timeout_err;

    logic          tb_ack;
    logic          loop_mode;

    // behavioural destination synchronizer
    logic          d_s1, d_s2, d_prev, enable_pulse;
    logic [BW-1:0] sync_bus;
    logic          dst_ack;
    int            dst_pulses;

    int n_checks;
    int n_fail;

    // transaction-level reference model
    int            m_phase;
    int            m_nxt;
    bit            m_seen;
    logic [BW-1:0] m_bus;
    bit            m_done;
    bit            m_err;
    int            m_wait;
    bit            ack_hist[$];
    logic [BW-1:0] done_q[$];
    logic [BW-1:0] dst_q[$];

    assign dst_ack   = d_s2;
    assign ack_async = loop_mode ? dst_ack : tb_ack;

    always #10 clk = ~clk;
    always #27 dst_clk = ~dst_clk;

    data_sync_launch #(
        .NUM_STAGES    (NS),
        .BUS_WIDTH     (BW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .ack_async  (ack_async),
        .unsync_bus (unsync_bus),
        .bus_enable (bus_enable),
        .done_pulse (done_pulse),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: ack is seen NS edges late; a word is in flight from accept until ack has risen and fallen.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0;
            m_bus   = '0;
            m_done  = 1'b0;
            m_err   = 1'b0;
            m_wait  = 0;
            ack_hist.delete();
            for (int i = 0; i < int'(NS); i++) ack_hist.push_back(1'b0);
            done_q.delete();
            dst_q.delete();
        end else begin
            m_seen = ack_hist[0];
            m_done = 1'b0;
            m_nxt  = m_phase;
            case (m_phase)
                0: if (data_valid && !m_seen) begin
                    m_bus = data_in;
                    m_nxt = 1;
                    done_q.push_back(data_in);
                    dst_q.push_back(data_in);
                end
                1: if (m_seen) m_nxt = 2;
                default: if (!m_seen) begin
                    m_nxt  = 0;
                    m_done = 1'b1;
                end
            endcase
            if (m_nxt != m_phase) begin
                m_wait = 0;
            end else if (m_phase != 0) begin
                if (m_wait < int'(TO)) m_wait++;
                if (m_wait == int'(TO)) m_err = 1'b1;
            end
            m_phase = m_nxt;
            void'(ack_hist.pop_front());
            ack_hist.push_back(ack_async);
        end
    end

    // Lockstep comparison of every output against the model, plus scoreboard pop on done.
    always @(negedge clk) begin
        if (ack_hist.size() != 0) begin
            check("data_ready", 32'(data_ready), 32'(m_phase == 0 && !ack_hist[0]));
            check("bus_enable", 32'(bus_enable), 32'(m_phase == 1));
            check("unsync_bus", 32'(unsync_bus), 32'(m_bus));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("done_pulse", 32'(done_pulse), 32'(m_done));
            check("timeout_err", 32'(timeout_err), 32'(m_err));
            if (done_pulse) begin
                if (done_q.size() == 0) begin
                    check("spurious done_pulse", 32'(1), 32'(0));
                end else begin
                    check("done word", 32'(unsync_bus), 32'(done_q.pop_front()));
                end
            end
        end
    end

    always @(posedge dst_clk or negedge rst) begin
        if (!rst) begin
            d_s1         <= 1'b0;
            d_s2         <= 1'b0;
            d_prev       <= 1'b0;
            enable_pulse <= 1'b0;
            sync_bus     <= '0;
        end else begin
            d_s1         <= bus_enable;
            d_s2         <= d_s1;
            d_prev       <= d_s2;
            enable_pulse <= d_s2 & ~d_prev;
            if (d_s2 && !d_prev) sync_bus <= unsync_bus;
        end
    end

    always @(negedge dst_clk) begin
        if (rst && enable_pulse) begin
            dst_pulses++;
            if (dst_q.size() == 0) begin
                check("spurious enable_pulse", 32'(1), 32'(0));
            end else begin
                check("sync_bus word", 32'(sync_bus), 32'(dst_q.pop_front()));
            end
        end
    end

    task automatic handshake();
        int g;
        tb_ack = 1'b1;
        g = 0;
        while (bus_enable && g < 50) begin
            tick();
            g++;
        end
        check("ack-high phase within bound", 32'(g < 50), 32'(1));
        tb_ack = 1'b0;
        g = 0;
        while (!done_pulse && g < 50) begin
            tick();
            g++;
        end
        check("ack-low phase within bound", 32'(g < 50), 32'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int done_seen;
        int pulses0;
        data_in    = '0;
        data_valid = 1'b0;
        tb_ack     = 1'b0;
        loop_mode  = 1'b0;
        n_checks   = 0;
        n_fail     = 0;
        dst_pulses = 0;

        // reset state
        #1 rst = 1'b0;
        #4;
        check("reset unsync_bus", 32'(unsync_bus), 32'(0));
        check("reset bus_enable", 32'(bus_enable), 32'(0));
        check("reset busy", 32'(busy), 32'(0));
        check("reset done_pulse", 32'(done_pulse), 32'(0));
        check("reset timeout_err", 32'(timeout_err), 32'(0));
        #40 rst = 1'b1;
        tick();

        // basic transfer with spec-literal edge timing
        data_in    = 8'hA5;
        data_valid = 1'b1;
        check("basic ready before accept", 32'(data_ready), 32'(1));
        tick();
        data_valid = 1'b0;
        data_in    = 8'hFF;
        check("basic unsync after accept", 32'(unsync_bus), 32'hA5);
        check("basic bus_enable after accept", 32'(bus_enable), 32'(1));
        check("basic ready after accept", 32'(data_ready), 32'(0));
        repeat (3) tick();
        tb_ack = 1'b1;
        repeat (2) tick();
        check("basic bus_enable edge5", 32'(bus_enable), 32'(1));
        tick();
        check("basic bus_enable edge6", 32'(bus_enable), 32'(0));
        repeat (2) tick();
        tb_ack = 1'b0;
        repeat (2) tick();
        check("basic done edge10", 32'(done_pulse), 32'(0));
        tick();
        check("basic done edge11", 32'(done_pulse), 32'(1));
        check("basic ready edge11", 32'(data_ready), 32'(1));
        tick();
        check("basic done edge12", 32'(done_pulse), 32'(0));

        // back-to-back with data_valid held high
        data_in    = 8'h11;
        data_valid = 1'b1;
        tick();
        data_in = 8'h22;
        tb_ack  = 1'b1;
        g = 0;
        while (bus_enable && g < 50) begin
            check("b2b bus held (ack high)", 32'(unsync_bus), 32'h11);
            tick();
            g++;
        end
        tb_ack = 1'b0;
        g = 0;
        while (!done_pulse && g < 50) begin
            check("b2b bus held (ack low)", 32'(unsync_bus), 32'h11);
            tick();
            g++;
        end
        check("b2b first done within bound", 32'(g < 50), 32'(1));
        check("b2b held in done cycle", 32'(unsync_bus), 32'h11);
        tick();
        data_valid = 1'b0;
        check("b2b second word accepted", 32'(unsync_bus), 32'h22);
        check("b2b second bus_enable", 32'(bus_enable), 32'(1));
        handshake();
        tick();

        // stale ack blocks acceptance
        tb_ack = 1'b1;
        repeat (3) tick();
        data_in    = 8'h77;
        data_valid = 1'b1;
        repeat (3) begin
            tick();
            check("stale ready low", 32'(data_ready), 32'(0));
            check("stale not busy", 32'(busy), 32'(0));
        end
        tb_ack = 1'b0;
        tick();
        check("stale ready 1 edge after fall", 32'(data_ready), 32'(0));
        tick();
        check("stale ready 2 edges after fall", 32'(data_ready), 32'(1));
        tick();
        data_valid = 1'b0;
        check("stale accepted word", 32'(unsync_bus), 32'h77);
        handshake();
        tick();

        // timeout with a late ack
        data_in    = 8'h3C;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        repeat (9) tick();
        check("timeout err after 9", 32'(timeout_err), 32'(0));
        tick();
        check("timeout err after 10", 32'(timeout_err), 32'(1));
        repeat (20) tick();
        check("timeout err sticky", 32'(timeout_err), 32'(1));
        check("timeout still requesting", 32'(bus_enable), 32'(1));
        handshake();
        check("timeout late transfer word", 32'(unsync_bus), 32'h3C);
        tick();
        check("timeout err after completion", 32'(timeout_err), 32'(1));

        // reset mid-REQ aborts the transfer
        data_in    = 8'h5A;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check("midreq bus_enable", 32'(bus_enable), 32'(1));
        #3 rst = 1'b0;
        #1;
        check("midreq reset unsync_bus", 32'(unsync_bus), 32'(0));
        check("midreq reset bus_enable", 32'(bus_enable), 32'(0));
        check("midreq reset busy", 32'(busy), 32'(0));
        check("midreq reset timeout_err", 32'(timeout_err), 32'(0));
        repeat (4) tick();
        rst = 1'b1;
        done_seen = 0;
        repeat (15) begin
            tick();
            if (done_pulse) done_seen++;
        end
        check("midreq no done after release", 32'(done_seen), 32'(0));

        // randomized loop through the destination synchronizer at 1:2.7
        loop_mode = 1'b1;
        pulses0   = dst_pulses;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) begin
                data_in = 8'($urandom);
                tick();
            end
            data_in    = 8'($urandom);
            data_valid = 1'b1;
            g = 0;
            while (!data_ready && g < 400) begin
                tick();
                g++;
            end
            check("loop ready within bound", 32'(g < 400), 32'(1));
            tick();
            data_valid = 1'b0;
            data_in    = 8'($urandom);
        end
        g = 0;
        while ((done_q.size() != 0 || dst_q.size() != 0 || busy) && g < 2000) begin
            tick();
            g++;
        end
        check("loop drained within bound", 32'(g < 2000), 32'(1));
        repeat (10) tick();
        check("loop one enable_pulse per word", 32'(dst_pulses - pulses0), 32'(6));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
